seq_divider: RTL and testbench
==============================

SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 Parameter: DATA_WIDTH, default 16, sets operand width W; dividend is 2W bits; quotient and remainder are W bits each.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 dividend  input  2W  signed two's-complement numerator; captured on the accepted start edge.
REQ-007 divisor  input  W  signed two's-complement denominator; captured on the accepted start edge.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 done  output  1  one-cycle pulse when results are valid.
REQ-010 quotient  output  W  signed quotient, truncated toward zero.
REQ-011 remainder  output  W  signed remainder; sign follows the dividend.
REQ-012 overflow  output  1  quotient not representable in W signed bits.
REQ-013 div_by_zero  output  1  divisor was zero.

Function
REQ-014 FSM states SHALL be: IDLE, LOAD, CALC, FIX, DONE.
REQ-015 IDLE->LOAD on an edge with start=1; otherwise stay in IDLE; start SHALL be ignored in every other state.
REQ-016 LOAD SHALL store the operand signs, |dividend| as 2W-bit unsigned, and |divisor| as W-bit unsigned.
REQ-017 LOAD SHALL clear the iteration counter.
REQ-018 LOAD->DONE if divisor==0; else LOAD->DONE if |dividend|[2W-1:W] >= |divisor| (pre-overflow); else LOAD->CALC.
REQ-019 CALC SHALL perform one restoring step per cycle: shift {rem,quot} left 1; trial = rem - |divisor| (W+1 bits); if non-negative, rem=trial and quot LSB=1, else quot LSB=0.
REQ-020 CALC SHALL run exactly W cycles; on the edge with counter==W-1, next state is FIX.
REQ-021 FIX SHALL negate quot if the dividend and divisor signs differ, and negate rem if the dividend is negative.
REQ-022 FIX SHALL set overflow if the positive quotient magnitude > 2^(W-1)-1 or the negative quotient magnitude > 2^(W-1); FIX->DONE.
REQ-023 DONE SHALL drive done=1 for exactly one cycle, then go DONE->IDLE.
REQ-024 Latency, normal path: done SHALL be high in the cycle after edge W+2, counting the start-sampling edge as edge 0.
REQ-025 Latency, zero-divisor or pre-overflow path: done SHALL be high after edge 2.
REQ-026 On div_by_zero: quotient=0, remainder=0, overflow=0.
REQ-027 On overflow: quotient saturates to 2^(W-1)-1 if the true result is positive, else -2^(W-1); remainder=0.
REQ-028 quotient, remainder, overflow and div_by_zero SHALL update only when entering DONE and hold until the next DONE.
REQ-029 Flags SHALL be cleared at LOAD of a new operation.
REQ-030 An operand of -2^(2W-1) or divisor -2^(W-1) SHALL be handled via unsigned magnitudes without loss.
REQ-031 start held high continuously SHALL start back-to-back operations, with IDLE lasting one cycle between them.

Reset
REQ-032 rst=1 SHALL force IDLE, counter 0, busy=0, done=0, quotient=0, remainder=0, overflow=0, div_by_zero=0, asynchronously.
REQ-033 Reset asserted mid-CALC SHALL abort the operation with no done pulse.
REQ-034 After reset deassertion, the next start SHALL complete normally.

Verification
REQ-035 dividend=100, divisor=7 (W=16) -> done after edge 18; quotient=14, remainder=2, flags 0.
REQ-036 dividend=-100, divisor=7 -> quotient=0xFFF2 (-14), remainder=0xFFFE (-2); dividend=100, divisor=-7 -> quotient=0xFFF2, remainder=2.
REQ-037 dividend=0x0000_1234, divisor=0 -> done after edge 2; div_by_zero=1, quotient=0, remainder=0.
REQ-038 dividend=0x0001_0000, divisor=1 -> pre-overflow, done after edge 2; overflow=1, quotient=0x7FFF.
REQ-039 dividend=0xFFFF_8000, divisor=1 -> quotient=0x8000, remainder=0, overflow=0.
REQ-040 dividend=0x0000_8000, divisor=1 -> FIX overflow: overflow=1, quotient=0x7FFF.
REQ-041 Reset pulse at CALC cycle 5 -> all outputs 0, no done; a following 100/7 yields 14 r 2.
REQ-042 start pulsed during busy -> ignored; result unchanged.

Source files
------------

// File: rtl/seq_divider.sv
// Sequential signed divider: 2W-bit dividend by W-bit divisor.
// It uses one restoring step per cycle on unsigned magnitudes, then fixes the signs.
// Quotient and remainder are W bits. The quotient truncates toward zero and the
// remainder takes the sign of the dividend. Overflow saturates the quotient.
module seq_divider #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic signed [2*DATA_WIDTH-1:0] dividend,
    input  logic signed [DATA_WIDTH-1:0]   divisor,
    output logic                           busy,
    output logic                           done,
    output logic signed [DATA_WIDTH-1:0]   quotient,
    output logic signed [DATA_WIDTH-1:0]   remainder,
    output logic                           overflow,
    output logic                           div_by_zero
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    // Largest quotient magnitudes that still fit in W signed bits.
    localparam logic [W-1:0] MAG_POS_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MAG_NEG_MAX = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t state;
    logic [CW-1:0] cnt;
    logic          short_q;

    // Operands captured when start is accepted.
    logic signed [2*W-1:0] dvd_q;
    logic signed [W-1:0]   dvs_q;

    // Magnitude datapath. {rem_q, quot_q} is the 2W-bit shift register.
    logic [W-1:0] rem_q;
    logic [W-1:0] quot_q;
    logic [W-1:0] mag_d;
    logic         neg_n;
    logic         neg_d;

    logic [2*W-1:0] dvd_mag_c;
    logic [W-1:0]   dvs_mag_c;
    logic           dvs_zero_c;
    logic           pre_ovf_c;
    logic           q_neg_c;
    logic [W:0]     wide_c;
    logic [W+1:0]   trial_c;
    logic           fits_c;
    logic [W-1:0]   rem_nxt;
    logic [W-1:0]   quot_nxt;
    logic           unused_trial_bit;

    // The unsigned magnitude of a 2W-bit value. The most negative value maps onto its exact magnitude.
    function automatic logic [2*W-1:0] mag_wide(input logic signed [2*W-1:0] v);
        logic [2*W-1:0] u;
        u = v;
        return u[2*W-1] ? -u : u;
    endfunction

    // The unsigned magnitude of a W-bit value.
    function automatic logic [W-1:0] mag_narrow(input logic signed [W-1:0] v);
        logic [W-1:0] u;
        u = v;
        return u[W-1] ? -u : u;
    endfunction

    // The saturated quotient for a result that does not fit in W signed bits.
    function automatic logic signed [W-1:0] sat_limit(input logic neg);
        return neg ? $signed(MAG_NEG_MAX) : $signed(MAG_POS_MAX);
    endfunction

    // True when an unsigned quotient magnitude is out of range for its sign.
    function automatic logic quot_ovf(input logic [W-1:0] mag, input logic neg);
        return neg ? (mag > MAG_NEG_MAX) : (mag > MAG_POS_MAX);
    endfunction

    // Applies a sign to an unsigned magnitude.
    function automatic logic signed [W-1:0] apply_sign(input logic [W-1:0] mag, input logic neg);
        return neg ? $signed(-mag) : $signed(mag);
    endfunction

    assign dvd_mag_c  = mag_wide(dvd_q);
    assign dvs_mag_c  = mag_narrow(dvs_q);
    assign dvs_zero_c = (dvs_q == '0);
    // The quotient needs more than W bits when the top half of |dividend| is not below |divisor|.
    assign pre_ovf_c  = (dvd_mag_c[2*W-1:W] >= dvs_mag_c);
    assign q_neg_c    = neg_n ^ neg_d;

    // One restoring step. rem_q is always below mag_d, so the accepted difference fits in W bits.
    assign wide_c           = {rem_q, quot_q[W-1]};
    assign trial_c          = {1'b0, wide_c} - {2'b00, mag_d};
    assign fits_c           = ~trial_c[W+1];
    assign rem_nxt          = fits_c ? trial_c[W-1:0] : wide_c[W-1:0];
    assign quot_nxt         = {quot_q[W-2:0], fits_c};
    assign unused_trial_bit = trial_c[W];

    // Operand capture and the magnitude shift/subtract datapath. These registers have no reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            dvd_q <= dividend;
            dvs_q <= divisor;
        end
        if (state == LOAD && !short_q) begin
            {rem_q, quot_q} <= dvd_mag_c;
            mag_d           <= dvs_mag_c;
            neg_n           <= dvd_q[2*W-1];
            neg_d           <= dvs_q[W-1];
        end else if (state == CALC) begin
            rem_q  <= rem_nxt;
            quot_q <= quot_nxt;
        end
    end

    // Control FSM with registered status, flag and result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            short_q     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    cnt <= '0;
                    if (!short_q) begin
                        overflow    <= 1'b0;
                        div_by_zero <= 1'b0;
                        // The zero-divisor and pre-overflow exits take a second LOAD cycle.
                        // Both exits then finish two edges after start, before any CALC step.
                        if (dvs_zero_c || pre_ovf_c) begin
                            short_q <= 1'b1;
                        end else begin
                            state <= CALC;
                        end
                    end else begin
                        short_q   <= 1'b0;
                        state     <= DONE;
                        done      <= 1'b1;
                        remainder <= '0;
                        if (dvs_zero_c) begin
                            div_by_zero <= 1'b1;
                            quotient    <= '0;
                        end else begin
                            overflow <= 1'b1;
                            quotient <= sat_limit(q_neg_c);
                        end
                    end
                end
                CALC: begin
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(W - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    state <= DONE;
                    done  <= 1'b1;
                    if (quot_ovf(quot_q, q_neg_c)) begin
                        overflow  <= 1'b1;
                        quotient  <= sat_limit(q_neg_c);
                        remainder <= '0;
                    end else begin
                        quotient  <= apply_sign(quot_q, q_neg_c);
                        remainder <= apply_sign(rem_q, neg_n);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Testbench for seq_divider (W=16).
// The reference model uses plain integer division to give quotient, remainder, flags and latency.
module tb_seq_divider;

    localparam int W = 16;

    logic                  clk;
    logic                  rst;
    logic                  start;
    logic signed [2*W-1:0] dividend;
    logic signed [W-1:0]   divisor;
    logic                  busy;
    logic                  done;
    logic signed [W-1:0]   quotient;
    logic signed [W-1:0]   remainder;
    logic                  overflow;
    logic                  div_by_zero;

    int checks   = 0;
    int failures = 0;

    seq_divider #(.DATA_WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .overflow    (overflow),
        .div_by_zero (div_by_zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: truncating division, saturation, and latency from the size of |a|/|b|.
    function automatic void model(input logic [31:0] a, input logic [15:0] b,
                                  output int lat, output logic [15:0] q, output logic [15:0] r,
                                  output logic ovf, output logic dz);
        longint sa, sb, ma, mb, qq, rr;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ovf = 1'b0;
        dz  = 1'b0;
        q   = '0;
        r   = '0;
        lat = W + 2;
        if (sb == 0) begin
            dz  = 1'b1;
            lat = 2;
            return;
        end
        ma = (sa < 0) ? -sa : sa;
        mb = (sb < 0) ? -sb : sb;
        qq = sa / sb;
        rr = sa % sb;
        if (ma / mb >= (longint'(1) << W)) lat = 2;
        if (qq > ((longint'(1) << (W - 1)) - 1) || qq < -(longint'(1) << (W - 1))) begin
            ovf = 1'b1;
            q   = (qq > 0) ? 16'h7FFF : 16'h8000;
        end else begin
            q = 16'(qq);
            r = 16'(rr);
        end
    endfunction

    // Waits for IDLE, presents the operands and returns after the start-sampling edge (edge 0).
    task automatic launch(input logic [31:0] a, input logic [15:0] b);
        int guard;
        guard = 0;
        @(negedge clk);
        while (busy && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Runs one operation and returns the edge number of done plus the sampled results.
    // When poke > 0, start is pulsed high for one cycle after that edge.
    task automatic run_op(input logic [31:0] a, input logic [15:0] b, input int poke,
                          output int lat, output logic [15:0] q, output logic [15:0] r,
                          output logic ovf, output logic dz, output logic dn_next);
        launch(a, b);
        lat = 0;
        for (int e = 1; e <= 40 && lat == 0; e++) begin
            @(posedge clk);
            #1;
            start = (e == poke);
            if (done === 1'b1) lat = e;
        end
        start = 1'b0;
        q   = quotient;
        r   = remainder;
        ovf = overflow;
        dz  = div_by_zero;
        @(posedge clk);
        #1 dn_next = done;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        dividend = '0;
        divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, quotient, remainder, overflow, div_by_zero} !== 36'd0) begin
            failures++;
            $display("FAIL reset_state: got busy=%b done=%b q=%h r=%h ovf=%b dz=%b, required all zero",
                     busy, done, quotient, remainder, overflow, div_by_zero);
        end
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, quotient, remainder, overflow, div_by_zero} !== 36'd0) begin
            failures++;
            $display("FAIL reset_release_idle: got busy=%b done=%b q=%h r=%h, required all zero",
                     busy, done, quotient, remainder);
        end
    endtask

    task automatic test_directed();
        logic [31:0] ta [11] = '{32'd100, -32'sd100, 32'd100, 32'h0000_1234, 32'h0001_0000,
                                 32'hFFFF_8000, 32'h0000_8000, 32'h8000_0000, 32'hC000_0000,
                                 32'h4000_0000, -32'sd7};
        logic [15:0] tb_ [11] = '{16'd7, 16'd7, -16'sd7, 16'd0, 16'd1, 16'd1, 16'd1,
                                  16'h8000, 16'h8000, 16'h8000, 16'd2};
        logic [15:0] tq [11] = '{16'd14, 16'hFFF2, 16'hFFF2, 16'h0000, 16'h7FFF, 16'h8000,
                                 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h8000, 16'hFFFD};
        logic [15:0] tr [11] = '{16'd2, 16'hFFFE, 16'd2, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0,
                                 16'd0, 16'd0, 16'hFFFF};
        logic tovf [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic tdz  [11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        int   tlat [11] = '{18, 18, 18, 2, 2, 18, 18, 2, 18, 18, 18};
        int lat;
        logic [15:0] q, r;
        logic ovf, dz, dn;
        for (int i = 0; i < 11; i++) begin
            run_op(ta[i], tb_[i], 0, lat, q, r, ovf, dz, dn);
            checks++;
            if ({lat, q, r, ovf, dz, dn} !== {tlat[i], tq[i], tr[i], tovf[i], tdz[i], 1'b0}) begin
                failures++;
                $display("FAIL directed[%0d] a=%h b=%h: got lat=%0d q=%h r=%h ovf=%b dz=%b done_next=%b, required lat=%0d q=%h r=%h ovf=%b dz=%b done_next=0",
                         i, ta[i], tb_[i], lat, q, r, ovf, dz, dn, tlat[i], tq[i], tr[i], tovf[i], tdz[i]);
            end
        end
    endtask

    task automatic test_random();
        int lat, elat;
        logic [15:0] q, r, eq, er, b;
        logic ovf, dz, dn, eovf, edz;
        logic [31:0] a;
        for (int i = 0; i < 60; i++) begin
            a = $urandom;
            a = $signed(a) >>> $urandom_range(0, 31);
            if ($urandom_range(0, 9) == 0) a = 32'h8000_0000;
            case ($urandom_range(0, 7))
                0: b = 16'h0000;
                1: b = 16'h8000;
                2: b = ($urandom_range(0, 1) != 0) ? 16'h0001 : 16'hFFFF;
                default: begin
                    b = 16'($urandom);
                    b = $signed(b) >>> $urandom_range(0, 15);
                end
            endcase
            model(a, b, elat, eq, er, eovf, edz);
            run_op(a, b, 0, lat, q, r, ovf, dz, dn);
            checks++;
            if ({lat, q, r, ovf, dz, dn} !== {elat, eq, er, eovf, edz, 1'b0}) begin
                failures++;
                $display("FAIL random[%0d] a=%h b=%h: got lat=%0d q=%h r=%h ovf=%b dz=%b done_next=%b, required lat=%0d q=%h r=%h ovf=%b dz=%b done_next=0",
                         i, a, b, lat, q, r, ovf, dz, dn, elat, eq, er, eovf, edz);
            end
        end
    endtask

    task automatic test_flag_clear_and_hold();
        int lat;
        logic [15:0] q, r;
        logic ovf, dz, dn;
        run_op(32'h0000_1234, 16'd0, 0, lat, q, r, ovf, dz, dn);
        launch(32'h0001_0000, 16'd1);
        @(posedge clk);
        #1;
        checks++;
        if (div_by_zero !== 1'b0) begin
            failures++;
            $display("FAIL dz_clear_at_load: got div_by_zero=%b, required 0", div_by_zero);
        end
        @(posedge clk);
        #1;
        while (busy) @(posedge clk);
        #1;
        launch(32'd100, 16'd7);
        @(posedge clk);
        #1;
        checks++;
        if ({overflow, quotient, remainder} !== {1'b0, 16'h7FFF, 16'h0000}) begin
            failures++;
            $display("FAIL ovf_clear_result_hold: got ovf=%b q=%h r=%h, required ovf=0 q=7fff r=0000",
                     overflow, quotient, remainder);
        end
        repeat (8) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, quotient} !== {1'b1, 1'b0, 16'h7FFF}) begin
            failures++;
            $display("FAIL result_hold_mid_calc: got busy=%b done=%b q=%h, required busy=1 done=0 q=7fff",
                     busy, done, quotient);
        end
        lat = 0;
        for (int e = 10; e <= 40 && lat == 0; e++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) lat = e;
        end
        checks++;
        if ({lat, quotient, remainder, overflow} !== {32'd18, 16'd14, 16'd2, 1'b0}) begin
            failures++;
            $display("FAIL after_clear_result: got lat=%0d q=%h r=%h ovf=%b, required lat=18 q=000e r=0002 ovf=0",
                     lat, quotient, remainder, overflow);
        end
    endtask

    task automatic test_reset_mid_calc();
        int lat;
        logic [15:0] q, r;
        logic ovf, dz, dn;
        logic seen_done;
        launch(32'd100, 16'd7);
        repeat (6) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, quotient, remainder, overflow, div_by_zero} !== 36'd0) begin
            failures++;
            $display("FAIL async_reset_mid_calc: got busy=%b done=%b q=%h r=%h ovf=%b dz=%b, required all zero",
                     busy, done, quotient, remainder, overflow, div_by_zero);
        end
        seen_done = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done) seen_done = 1'b1;
        end
        rst = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done) seen_done = 1'b1;
        end
        checks++;
        if ({seen_done, busy} !== 2'b00) begin
            failures++;
            $display("FAIL abort_no_done: got seen_done=%b busy=%b, required 0 0", seen_done, busy);
        end
        run_op(32'd100, 16'd7, 0, lat, q, r, ovf, dz, dn);
        checks++;
        if ({lat, q, r, ovf, dz} !== {32'd18, 16'd14, 16'd2, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL op_after_reset: got lat=%0d q=%h r=%h ovf=%b dz=%b, required lat=18 q=000e r=0002 flags 0",
                     lat, q, r, ovf, dz);
        end
    endtask

    task automatic test_start_while_busy();
        int lat, elat;
        logic [15:0] q, r, eq, er;
        logic ovf, dz, dn, eovf, edz;
        logic extra;
        model(32'd12345, -16'sd17, elat, eq, er, eovf, edz);
        run_op(32'd12345, -16'sd17, 6, lat, q, r, ovf, dz, dn);
        checks++;
        if ({lat, q, r, ovf, dz, dn} !== {elat, eq, er, eovf, edz, 1'b0}) begin
            failures++;
            $display("FAIL start_ignored_result: got lat=%0d q=%h r=%h ovf=%b dz=%b, required lat=%0d q=%h r=%h ovf=%b dz=%b",
                     lat, q, r, ovf, dz, elat, eq, er, eovf, edz);
        end
        extra = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (busy || done) extra = 1'b1;
        end
        checks++;
        if (extra !== 1'b0) begin
            failures++;
            $display("FAIL start_ignored_no_restart: got activity=%b, required 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        int first, second, elat;
        logic busy_idle, busy_again;
        logic [15:0] q1, r1, q2, r2, eq, er;
        logic eovf, edz;
        model(-32'sd1000, 16'd9, elat, eq, er, eovf, edz);
        @(negedge clk);
        while (busy) @(negedge clk);
        dividend = 32'd100;
        divisor  = 16'd7;
        start    = 1'b1;
        @(posedge clk);
        first = 0;
        second = 0;
        busy_idle = 1'b1;
        busy_again = 1'b0;
        q1 = '0;
        r1 = '0;
        q2 = '0;
        r2 = '0;
        for (int e = 1; e <= 60 && second == 0; e++) begin
            @(posedge clk);
            #1;
            if (first != 0 && e == first + 1) busy_idle = busy;
            if (first != 0 && e == first + 2) busy_again = busy;
            if (done && first == 0) begin
                first = e;
                q1 = quotient;
                r1 = remainder;
                dividend = -32'sd1000;
                divisor = 16'd9;
            end else if (done && first != 0) begin
                second = e;
                q2 = quotient;
                r2 = remainder;
                start = 1'b0;
            end
        end
        start = 1'b0;
        checks++;
        if ({first, q1, r1} !== {32'd18, 16'd14, 16'd2}) begin
            failures++;
            $display("FAIL b2b_first: got edge=%0d q=%h r=%h, required edge=18 q=000e r=0002", first, q1, r1);
        end
        checks++;
        if ({busy_idle, busy_again} !== 2'b01) begin
            failures++;
            $display("FAIL b2b_idle_gap: got busy after done+1=%b done+2=%b, required 0 1", busy_idle, busy_again);
        end
        checks++;
        if ({second, q2, r2} !== {32'd38, eq, er}) begin
            failures++;
            $display("FAIL b2b_second: got edge=%0d q=%h r=%h, required edge=38 q=%h r=%h", second, q2, r2, eq, er);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_flag_clear_and_hold();
        test_reset_mid_calc();
        test_start_while_busy();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
